// File: rtl/execute_mc_if.sv
// Handshake and datapath bundle between the ID/EXE register, the execute stage and EXE/MEM.
interface execute_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluc;
  logic             aluimm;
  logic             shift;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             z;
  logic             busy;

  modport master (
    output in_valid, aluc, aluimm, shift, a, b, imm, out_ready,
    input  in_ready, out_valid, result, z, busy
  );

  modport slave (
    input  in_valid, aluc, aluimm, shift, a, b, imm, out_ready,
    output in_ready, out_valid, result, z, busy
  );
endinterface

// File: rtl/execute_mc.sv
// Multi-cycle execute stage: single-cycle ALU ops plus iterative unsigned multiply/divide,
// with a registered result/zero flag held under downstream backpressure.
module execute_mc #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SA_LSB = 5
) (
  input logic         clk,
  input logic         clrn,
  execute_mc_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e             state_q;
  logic [SW-1:0]      count_q;
  logic               op_hi_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   result_q;
  logic               z_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;
  logic [WIDTH-1:0]   div_res;

  assign sa    = {{(WIDTH-SW){1'b0}}, bus.imm[SA_LSB +: SW]};
  assign op_a  = bus.shift ? sa : bus.a;
  assign op_b  = bus.aluimm ? bus.imm : bus.b;
  assign shamt = op_a[SW-1:0];

  assign is_mul   = (bus.aluc[3:1] == 3'b101);
  assign is_div   = (bus.aluc[3:1] == 3'b110);
  assign in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (bus.aluc)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_b << (WIDTH / 2);
      4'd6:    alu_res = op_b << shamt;
      4'd7:    alu_res = op_b >> shamt;
      4'd8:    alu_res = $signed(op_b) >>> shamt;
      4'd9:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // The final iteration's contribution is folded in combinationally so the result lands
  // on the same edge as the last step.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res  = op_hi_q ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];

  // Restoring step; a zero divisor always "fits", yielding all-ones quotient and rem = A.
  assign div_shift = {rem_q, quot_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, divisor_q};
  assign div_ge    = !div_diff[WIDTH];
  assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quot_next = {quot_q[WIDTH-2:0], div_ge};
  assign div_res   = op_hi_q ? rem_next : quot_next;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= StIdle;
      count_q     <= '0;
      op_hi_q     <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_hi_q <= bus.aluc[0];
            if (is_mul) begin
              mcand_q     <= {{WIDTH{1'b0}}, op_a};
              mplier_q    <= op_b;
              acc_q       <= '0;
              count_q     <= SW'(WIDTH - 1);
              out_valid_q <= 1'b0;
              state_q     <= StMul;
            end else if (is_div) begin
              quot_q      <= op_a;
              divisor_q   <= op_b;
              rem_q       <= '0;
              count_q     <= SW'(WIDTH - 1);
              out_valid_q <= 1'b0;
              state_q     <= StDiv;
            end else begin
              result_q    <= alu_res;
              z_q         <= (alu_res == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        StMul: begin
          if (count_q == '0) begin
            result_q    <= mul_res;
            z_q         <= (mul_res == '0);
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - SW'(1);
          end
        end
        StDiv: begin
          if (count_q == '0) begin
            result_q    <= div_res;
            z_q         <= (div_res == '0);
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            rem_q   <= rem_next;
            quot_q  <= quot_next;
            count_q <= count_q - SW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.z         = z_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_execute_mc.sv
// Self-checking bench for execute_mc: directed corner cases plus random ops against an
// arithmetic reference model.
module tb_execute_mc;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic clrn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  execute_mc_if #(.WIDTH(W)) bus ();

  execute_mc #(.WIDTH(W), .SA_LSB(5)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return y << 16;
      4'd6:  return y << x[4:0];
      4'd7:  return y >> x[4:0];
      4'd8:  return 32'($signed(y) >>> x[4:0]);
      4'd9:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      4'd13: return (y == 32'd0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic ai, input logic sh,
                       input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] ri);
    bus.aluc   = op;
    bus.aluimm = ai;
    bus.shift  = sh;
    bus.a      = ra;
    bus.b      = rb;
    bus.imm    = ri;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic ai, input logic sh,
                        input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] ri);
    logic [31:0] x, y, exp;
    int          n;
    bit          busy_ok;
    x   = sh ? {27'd0, ri[9:5]} : ra;
    y   = ai ? ri : rb;
    exp = model(op, x, y);
    n   = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    drive(op, ai, sh, ra, rb, ri);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (op inside {[4'd10:4'd13]}) begin
      busy_ok = 1'b1;
      n       = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) busy_ok = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      check({tag, " latency"}, 64'(n), 64'd32);
      check({tag, " busy"}, 64'(busy_ok), 64'd1);
      check({tag, " busy_end"}, 64'(bus.busy), 64'd0);
    end
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, " result"}, 64'(bus.result), 64'(exp));
    check({tag, " z"}, 64'(bus.z), 64'(exp == 32'd0));
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb, ri;

    clrn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst result", 64'(bus.result), 64'd0);
    check("rst z", 64'(bus.z), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    #12 clrn = 1'b1;
    @(posedge clk); #1;
    check("post-rst in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back single-cycle ops.
    drive(4'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b add result", 64'(bus.result), 64'd12);
    check("b2b add z", 64'(bus.z), 64'd0);
    check("b2b add in_ready", 64'(bus.in_ready), 64'd1);
    drive(4'd1, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b sub result", 64'(bus.result), 64'd0);
    check("b2b sub z", 64'(bus.z), 64'd1);
    check("b2b sub out_valid", 64'(bus.out_valid), 64'd1);
    check("b2b sub in_ready", 64'(bus.in_ready), 64'd1);

    // Shift amount from the immediate field.
    run_op("sra imm", 4'd8, 1'b0, 1'b1, 32'd0, 32'h8000_0001, 32'h0000_0080);
    check("sra const", 64'(bus.result), 64'hF800_0000);
    run_op("srl imm", 4'd7, 1'b0, 1'b1, 32'd0, 32'h8000_0001, 32'h0000_0080);
    check("srl const", 64'(bus.result), 64'h0800_0000);

    run_op("mulu max", 4'd10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    check("mulu const", 64'(bus.result), 64'h0000_0001);
    run_op("mulhu max", 4'd11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    check("mulhu const", 64'(bus.result), 64'hFFFF_FFFE);

    run_op("divu 100/7", 4'd12, 1'b0, 1'b0, 32'd100, 32'd7, 32'd0);
    check("divu const", 64'(bus.result), 64'd14);
    run_op("remu 100/7", 4'd13, 1'b0, 1'b0, 32'd100, 32'd7, 32'd0);
    check("remu const", 64'(bus.result), 64'd2);
    run_op("divu 5/0", 4'd12, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0);
    check("divu0 const", 64'(bus.result), 64'hFFFF_FFFF);
    run_op("remu 5/0", 4'd13, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0);
    check("remu0 const", 64'(bus.result), 64'd5);

    // Backpressure: hold the ADD result for 3 cycles with a SUB pending.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(4'd0, 1'b0, 1'b0, 32'd20, 32'd22, 32'd0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(4'd1, 1'b0, 1'b0, 32'd10, 32'd3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp in_ready", 64'(bus.in_ready), 64'd0);
      check("bp out_valid", 64'(bus.out_valid), 64'd1);
      check("bp result", 64'(bus.result), 64'd42);
      check("bp z", 64'(bus.z), 64'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp next result", 64'(bus.result), 64'd7);
    check("bp next out_valid", 64'(bus.out_valid), 64'd1);

    // Reset in the middle of a divide aborts it.
    drive(4'd12, 1'b0, 1'b0, 32'd1000, 32'd3, 32'd0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid-div busy", 64'(bus.busy), 64'd1);
    clrn = 1'b0;
    #1;
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort result", 64'(bus.result), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    #2 clrn = 1'b1;
    run_op("post-abort add", 4'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
    check("post-abort const", 64'(bus.result), 64'd2);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      ri  = $urandom;
      run_op($sformatf("rand%0d op%0d", i, rop), rop, 1'($urandom), 1'($urandom), ra, rb, ri);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised multi-cycle execute stage for the pipelined CPU. It takes decoded operands through a valid/ready handshake and selects ALU inputs: the register operand or the shift amount, and the register operand or the immediate. Single-cycle ALU operations complete in one cycle; unsigned multiply and divide run iteratively. It sits between the ID/EXE pipeline register and the EXE/MEM register and presents a registered result with a zero flag under output backpressure.

## Interface
- WIDTH, 32: datapath width; even, >= 8.
- SA_LSB, 5: LSB of the shift-amount field inside imm; field width SW = $clog2(WIDTH).
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an operation.
- in_ready  out  1  stage can accept this cycle.
- aluc  in  4  operation code (below).
- aluimm  in  1  1: ALU B input = imm; 0: ALU B input = b.
- shift  in  1  1: ALU A input = zero-extended imm[SA_LSB +: SW]; 0: ALU A input = a.
- a, b, imm  in  WIDTH each  register operands, extended immediate.
- out_valid  out  1  result/z valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  registered result.
- z  out  1  registered flag, result == 0.
- busy  out  1  multiply/divide iteration in progress.

## Operation
- Operand muxes:
  - A = shift ? sa : a.
  - B = aluimm ? imm : b.
- aluc encoding:
  - 0 ADD: A+B, mod 2^WIDTH.
  - 1 SUB: A-B, mod 2^WIDTH.
  - 2 AND. 3 OR. 4 XOR.
  - 5 LUI: B << WIDTH/2.
  - 6 SLL: B << A[SW-1:0].
  - 7 SRL: B >> A[SW-1:0], logical.
  - 8 SRA: B >>> A[SW-1:0], arithmetic.
  - 9 SLT: signed A<B gives 1, else 0.
  - 10 MULU: low half of A*B. 11 MULHU: high half.
  - 12 DIVU: A/B quotient. 13 REMU: A%B remainder.
  - 14, 15: result 0, z=1, completes in a single cycle.
- Divide by zero: quotient = all ones; remainder = A. Normal iteration, no exception.
- Transfer: an operation transfers on a clock edge where in_valid & in_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- FSM states: IDLE, MUL, DIV.
  - IDLE, single-cycle op accepted: result, z and out_valid=1 written at the accept edge; stay in IDLE.
  - IDLE, op 10/11 accepted: load the multiplicand, multiplier and a 2*WIDTH accumulator; count = WIDTH-1; out_valid cleared; go to MUL.
  - IDLE, op 12/13 accepted: load the restoring-divider dividend/divisor registers; remainder = 0; count = WIDTH-1; out_valid cleared; go to DIV.
  - MUL: shift-add one multiplier bit per cycle. At count==0, write the selected half to result, set z, set out_valid=1, go to IDLE. Otherwise decrement count.
  - DIV: one restoring step per cycle. At count==0, write the quotient or remainder and z, set out_valid=1, go to IDLE.
- Output register: holds result/z while out_valid & !out_ready.
  - Clears out_valid on an edge with out_ready and no new single-cycle write.
- busy = (state != IDLE).

## Timing
- Reset (clrn=0, async), values asserted immediately and held until release:
  - state=IDLE, out_valid=0, result=0, z=0 (result 0 is not flagged while out_valid=0), busy=0.
  - Counters and iteration registers are zeroed.
  - in_ready=1 from the first edge after release.
- Reset during MUL/DIV aborts the operation. No result is produced.
- Single-cycle ops:
  - out_valid rises at the accept edge (latency 1).
  - Throughput is 1 per cycle while out_ready=1.
- MUL/DIV ops:
  - Accepted at edge k; out_valid rises at edge k+WIDTH.
  - in_ready=0 for edges k+1..k+WIDTH.
  - Next accept is possible in the cycle after edge k+WIDTH, provided out_ready is high in that cycle.
- Simultaneous events:
  - With out_valid=1, out_ready=1 and an in_valid single-cycle op, the old result retires and the new one loads on the same edge; out_valid stays 1.
  - With a MUL/DIV op in the same situation, out_valid goes to 0.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and outputs are stable.
- Inputs are sampled only at the accept edge. Operand changes during MUL/DIV are ignored.

## Test plan
- Back-to-back, out_ready=1: ADD a=5,b=7 then SUB a=9,b=9 on consecutive cycles. Required: result 12,z=0 at the first accept edge, then 0,z=1 at the second; in_ready stays 1.
- Shift via immediate: shift=1, imm[9:5]=4, b=0x80000001, SRA. Required: result 0xF8000000. Repeat with SRL: required 0x08000000.
- MUL, WIDTH=32: MULU A=B=0xFFFFFFFF. Required: result 0x00000001, out_valid exactly 32 edges after accept, busy high for those 32 cycles. Repeat with MULHU: required 0xFFFFFFFE.
- DIV: DIVU 100/7 gives 14; REMU 100/7 gives 2. DIVU 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5.
- Backpressure: out_ready=0 for 3 cycles after an ADD result. Required: result and z stable, in_ready=0; the next op is accepted on the edge where out_ready returns to 1.
- Reset mid-divide: assert clrn=0 at iteration 10 of a DIVU. Required: out_valid=0, result=0, busy=0 immediately. After release, ADD 1+1 gives 2 with latency 1.
